// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : spi_cmd_pkg
//  Brief   : Shared definitions for the SPI command sequencer: sequencer
//            state encoding, header bit-field positions and default
//            parameter values.
//  Rev     : 1.0  initial release
// ============================================================================
package spi_cmd_pkg;

  // Default parameter values for spi_cmd_seq / spi_cmd_timeout.
  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_ADDR_W      = 7;
  localparam int DEFAULT_MAX_LEN     = 16;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  // Header byte layout: start address sits at the bottom of the byte,
  // the write flag is the most significant bit of the byte.
  localparam int HDR_ADDR_LSB = 0;

  function automatic int hdr_wr_bit(input int data_w);
    return data_w - 1;
  endfunction

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNT    = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_ERROR    = 3'd5
  } spi_state_e;

endpackage : spi_cmd_pkg
`default_nettype wire

// File: rtl/spi_cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module  : spi_cmd_timeout
//  Brief   : Inter-byte timer. Counts clock cycles while not cleared and
//            flags expiry on the cycle the count reaches TIMEOUT_CYC.
//  Ports   : clk       in  clock
//            reset     in  synchronous active-high reset
//            i_clear   in  hold timer at zero (byte arrived / not waiting)
//            o_expired out one-cycle flag: TIMEOUT_CYC cycles of silence
//  Rev     : 1.0  initial release
// ============================================================================
module spi_cmd_timeout
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_expired
);

  // The timer only has to reach TIMEOUT_CYC-1; the expiry cycle itself is
  // the TIMEOUT_CYC-th cycle of silence.
  localparam int              CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  always_comb begin
    timer_d   = timer_q + 1'b1;
    o_expired = 1'b0;
    if (i_clear) begin
      timer_d = '0;
    end else if (timer_q == LAST) begin
      o_expired = 1'b1;
      timer_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule : spi_cmd_timeout
`default_nettype wire

// File: rtl/spi_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module  : spi_cmd_seq
//  Brief   : Turns SPI byte frames into register-bus accesses.
//            Frame: header (MSB = write, low ADDR_W bits = start address),
//            count N, then N data bytes for writes. Reads are issued
//            back-to-back. Any frame error sets a sticky err flag that is
//            cleared by the next header byte.
//  Build   : define SPI_CMD_TIMEOUT_EN to add an inter-byte timeout while
//            waiting for the count or a write data byte.
//  Ports   : clk              in  clock
//            reset            in  synchronous active-high reset
//            SPI_done         in  received-byte strobe
//            SPI_rx_data      in  received byte (valid with SPI_done)
//            SPI_cs_n         in  chip select, high aborts the frame
//            cmd_ready        in  register bus accepts access
//            cmd_valid        out register access pending
//            cmd_write        out 1 = write, 0 = read
//            cmd_addr         out register address
//            cmd_wdata        out write data (zero for reads)
//            SPI_CMD_reading  out high while issuing reads
//            err              out sticky frame error
//  Rev     : 1.0  initial release
// ============================================================================
module spi_cmd_seq
  import spi_cmd_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPI_done,
  input  logic [DATA_W-1:0] SPI_rx_data,
  input  logic              SPI_cs_n,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              SPI_CMD_reading,
  output logic              err
);

  localparam int              WR_BIT    = hdr_wr_bit(DATA_W);
  localparam logic [DATA_W-1:0] MAX_LEN_V = DATA_W'(MAX_LEN);
  localparam logic [DATA_W-1:0] ONE_V     = DATA_W'(1);

  spi_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q,   err_d;

  logic              accept;
  logic              timeout_hit;

  // --------------------------------------------------------------------------
  // Optional inter-byte timeout
  // --------------------------------------------------------------------------
`ifdef SPI_CMD_TIMEOUT_EN
  logic tmo_clear;

  // Timer runs only while waiting for a byte in COUNT or WR_DATA.
  assign tmo_clear = SPI_done ||
                     !((state_q == ST_COUNT) || (state_q == ST_WR_DATA));

  spi_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (tmo_clear),
    .o_expired (timeout_hit)
  );
`else
  // No timer in this build; the parameter is kept so both builds share one
  // parameter list, and this expression is constant false.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // --------------------------------------------------------------------------
  // Outputs decode straight from registered state
  // --------------------------------------------------------------------------
  assign cmd_valid       = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
  assign cmd_write       = write_q;
  assign cmd_addr        = addr_q;
  assign cmd_wdata       = wdata_q;
  assign SPI_CMD_reading = (state_q == ST_RD_ISSUE);
  assign err             = err_q;

  // Chip select high cancels any access presented in the same cycle.
  assign accept = cmd_valid && cmd_ready && !SPI_cs_n;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    if (SPI_cs_n) begin
      state_d = ST_IDLE;
      // Losing chip select while a frame still expects bytes or a write is
      // outstanding is a frame error; an idle bus or a read burst is not.
      if ((state_q == ST_COUNT) || (state_q == ST_WR_DATA) ||
          (state_q == ST_WR_ISSUE)) begin
        err_d = 1'b1;
      end
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (SPI_done) begin
            write_d = SPI_rx_data[WR_BIT];
            addr_d  = SPI_rx_data[HDR_ADDR_LSB +: ADDR_W];
            wdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (SPI_done) begin
            if ((SPI_rx_data == '0) || (SPI_rx_data > MAX_LEN_V)) begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end else begin
              count_d = SPI_rx_data;
              state_d = write_q ? ST_WR_DATA : ST_RD_ISSUE;
            end
          end
        end

        ST_WR_DATA: begin
          if (SPI_done) begin
            wdata_d = SPI_rx_data;
            state_d = ST_WR_ISSUE;
          end
        end

        ST_WR_ISSUE: begin
          if (accept) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q - 1'b1;
            state_d = (count_q == ONE_V) ? ST_IDLE : ST_WR_DATA;
          end
          // A byte arriving before the previous write drained is an overrun;
          // it is dropped and the frame is abandoned.
          if (SPI_done) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end

        ST_RD_ISSUE: begin
          // Bytes clocked in during a read burst carry no meaning.
          if (accept) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q - 1'b1;
            if (count_q == ONE_V) begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_ERROR: begin
          // Held until chip select is released.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule : spi_cmd_seq
`default_nettype wire

// File: tb/tb_spi_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_spi_cmd_seq
//  Brief   : Self-checking bench for spi_cmd_seq. Directed frames plus
//            randomized frames; expected register accesses are queued when a
//            frame is issued and compared by an independent bus monitor.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_spi_cmd_seq;
  import spi_cmd_pkg::*;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       SPI_done;
  logic [7:0] SPI_rx_data;
  logic       SPI_cs_n;
  logic       cmd_ready;
  logic       cmd_valid;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       SPI_CMD_reading;
  logic       err;

  spi_cmd_seq #(
    .DATA_W      (8),
    .ADDR_W      (7),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .SPI_done        (SPI_done),
    .SPI_rx_data     (SPI_rx_data),
    .SPI_cs_n        (SPI_cs_n),
    .cmd_ready       (cmd_ready),
    .cmd_valid       (cmd_valid),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .SPI_CMD_reading (SPI_CMD_reading),
    .err             (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready && !SPI_cs_n) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_access", {cmd_write, cmd_addr, cmd_wdata}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_write",   cmd_write,       e.w);
        chk("acc_addr",    cmd_addr,        e.a);
        chk("acc_wdata",   cmd_wdata,       e.d);
        chk("acc_reading", SPI_CMD_reading, !e.w);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rdy_rand) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    SPI_done    = 1'b1;
    SPI_rx_data = b;
    cyc();
    SPI_done    = 1'b0;
    SPI_rx_data = 8'($urandom);
  endtask

  task automatic cs_pulse();
    SPI_cs_n = 1'b1;
    cyc();
    SPI_cs_n = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 300) begin
      cyc();
      n++;
    end
    chk("accept_count", acc_cnt, target);
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state_q);
  endfunction

  // Issue one frame; len_ok says whether the count byte is legal.
  task automatic run_frame(input bit wr, input logic [6:0] a, input int n);
    logic [7:0] d;
    logic [7:0] nb;
    int         base;
    bit         len_ok;
    len_ok = (n >= 1) && (n <= MAX_LEN);
    nb     = 8'(n);
    base   = acc_cnt;
    send_byte({wr, a});
    if (!len_ok) begin
      send_byte(nb);
      chk("badlen_state", st(), 32'(ST_ERROR));
      chk("badlen_err", err, 1'b1);
      cs_pulse();
      chk("badlen_recover", st(), 32'(ST_IDLE));
      return;
    end
    if (wr) begin
      send_byte(nb);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        exp_q.push_back('{w: 1'b1, a: 7'(a + 7'(i)), d: d});
        send_byte(d);
        wait_acc(base + i + 1);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{w: 1'b0, a: 7'(a + 7'(i)), d: 8'h00});
      end
      send_byte(nb);
      wait_acc(base + n);
    end
    chk("frame_end_state", st(), 32'(ST_IDLE));
    chk("frame_end_err", err, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset       = 1'b1;
    SPI_done    = 1'b0;
    SPI_rx_data = 8'h00;
    SPI_cs_n    = 1'b0;
    cmd_ready   = 1'b0;
    cyc(); cyc(); cyc();

    // Reset values
    chk("rst_state", st(), 32'(ST_IDLE));
    chk("rst_outputs", {cmd_valid, cmd_write, cmd_addr, cmd_wdata, SPI_CMD_reading, err}, 32'h0);
    chk("rst_count", 32'(dut.count_q), 32'h0);
    reset = 1'b0;
    cyc();

    // Write burst, bus always ready
    cmd_ready = 1'b1;
    base = acc_cnt;
    exp_q.push_back('{w: 1'b1, a: 7'h05, d: 8'hAA});
    exp_q.push_back('{w: 1'b1, a: 7'h06, d: 8'hBB});
    send_byte(8'h85);
    send_byte(8'h02);
    send_byte(8'hAA);
    chk("wr_latency_valid", cmd_valid, 1'b1);
    wait_acc(base + 1);
    send_byte(8'hBB);
    wait_acc(base + 2);
    chk("wr_burst_state", st(), 32'(ST_IDLE));
    chk("wr_burst_err", err, 1'b0);

    // Read burst with two stall cycles and address wrap
    cmd_ready = 1'b0;
    base = acc_cnt;
    exp_q.push_back('{w: 1'b0, a: 7'h7E, d: 8'h00});
    exp_q.push_back('{w: 1'b0, a: 7'h7F, d: 8'h00});
    exp_q.push_back('{w: 1'b0, a: 7'h00, d: 8'h00});
    send_byte(8'h7E);
    send_byte(8'h03);
    for (int i = 0; i < 2; i++) begin
      chk("rd_stall_outputs", {cmd_valid, cmd_write, cmd_addr, cmd_wdata, SPI_CMD_reading},
          {1'b1, 1'b0, 7'h7E, 8'h00, 1'b1});
      cyc();
    end
    cmd_ready = 1'b1;
    cyc();
    chk("rd_no_gap_valid", cmd_valid, 1'b1);
    cyc();
    chk("rd_no_gap_valid2", cmd_valid, 1'b1);
    wait_acc(base + 3);
    chk("rd_burst_state", st(), 32'(ST_IDLE));
    chk("rd_burst_reading", SPI_CMD_reading, 1'b0);

    // Zero count error, ERROR ignores bytes, cs_n leaves, header clears err
    send_byte(8'h80);
    send_byte(8'h00);
    chk("cnt0_state", st(), 32'(ST_ERROR));
    chk("cnt0_err", err, 1'b1);
    chk("cnt0_valid", cmd_valid, 1'b0);
    send_byte(8'h42);
    chk("error_ignores_byte", st(), 32'(ST_ERROR));
    cs_pulse();
    chk("error_cs_idle", st(), 32'(ST_IDLE));
    chk("error_err_sticky", err, 1'b1);
    base = acc_cnt;
    exp_q.push_back('{w: 1'b0, a: 7'h01, d: 8'h00});
    send_byte(8'h01);
    chk("hdr_clears_err", err, 1'b0);
    chk("hdr_state_count", st(), 32'(ST_COUNT));
    send_byte(8'h01);
    wait_acc(base + 1);

    // Over-long count
    run_frame(1'b0, 7'h10, MAX_LEN + 1);

    // Overrun
    cmd_ready = 1'b0;
    send_byte(8'h83);
    send_byte(8'h02);
    send_byte(8'h11);
    cyc();
    chk("ovr_valid_pending", cmd_valid, 1'b1);
    send_byte(8'h22);
    chk("ovr_err", err, 1'b1);
    chk("ovr_valid_drop", cmd_valid, 1'b0);
    chk("ovr_state", st(), 32'(ST_ERROR));
    cs_pulse();

    // Abort in WR_ISSUE with cmd_ready high the same cycle
    base = acc_cnt;
    send_byte(8'h90);
    send_byte(8'h02);
    send_byte(8'h5A);
    chk("abort_pre_valid", cmd_valid, 1'b1);
    SPI_cs_n  = 1'b1;
    cmd_ready = 1'b1;
    cyc();
    SPI_cs_n  = 1'b0;
    cmd_ready = 1'b0;
    chk("abort_state", st(), 32'(ST_IDLE));
    chk("abort_err", err, 1'b1);
    chk("abort_valid", cmd_valid, 1'b0);
    chk("abort_no_accept", acc_cnt, base);

    // cs_n in RD_ISSUE does not set err
    send_byte(8'h20);
    send_byte(8'h04);
    cs_pulse();
    chk("rd_abort_state", st(), 32'(ST_IDLE));
    chk("rd_abort_err", err, 1'b0);

    // Reset mid read burst
    cmd_ready = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back('{w: 1'b0, a: 7'(7'h30 + 7'(i)), d: 8'h00});
    send_byte(8'h30);
    send_byte(8'h05);
    wait_acc(base + 2);
    reset = 1'b1;
    cyc();
    chk("midrst_outputs", {cmd_valid, cmd_write, cmd_addr, cmd_wdata, SPI_CMD_reading, err}, 32'h0);
    chk("midrst_state", st(), 32'(ST_IDLE));
    exp_q.delete();
    reset = 1'b0;
    cyc();

    // Inter-byte timeout / indefinite wait
    send_byte(8'h01);
`ifdef SPI_CMD_TIMEOUT_EN
    for (int i = 0; i < 7; i++) cyc();
    chk("tmo_before", st(), 32'(ST_COUNT));
    cyc();
    chk("tmo_state", st(), 32'(ST_IDLE));
    chk("tmo_err", err, 1'b1);
`else
    for (int i = 0; i < 40; i++) cyc();
    chk("notmo_state", st(), 32'(ST_COUNT));
    chk("notmo_err", err, 1'b0);
    cs_pulse();
    chk("cs_in_count_err", err, 1'b1);
`endif

    // Randomized frames with random bus back-pressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int  n;
      bit  wr;
      logic [6:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      if ($urandom_range(0, 9) == 0)
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      else
        n = int'($urandom_range(1, MAX_LEN));
      run_frame(wr, a, n);
      cyc();
    end
    rdy_rand = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_spi_cmd_seq
`default_nettype wire

// File: doc/spi_cmd_seq.md
SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of SPI byte and register data.
REQ-002 SHALL have parameter ADDR_W, default 7, register address width, at most DATA_W-1.
REQ-003 SHALL have parameter MAX_LEN, default 16, maximum burst count per frame, range 1..2^DATA_W-1.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, inter-byte timeout in clk cycles, minimum 2.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port SPI_done  in  1  one-cycle strobe; a received byte is on SPI_rx_data.
REQ-008 SHALL have port SPI_rx_data  in  DATA_W  received byte, valid only with SPI_done.
REQ-009 SHALL have port SPI_cs_n  in  1  chip select; high aborts any frame.
REQ-010 SHALL have port cmd_ready  in  1  register-bus accept.
REQ-011 SHALL have port cmd_valid  out  1  register access pending.
REQ-012 SHALL have port cmd_write  out  1  1 = write, 0 = read.
REQ-013 SHALL have port cmd_addr  out  ADDR_W  register address.
REQ-014 SHALL have port cmd_wdata  out  DATA_W  write data; zero for reads.
REQ-015 SHALL have port SPI_CMD_reading  out  1  high while in RD_ISSUE.
REQ-016 SHALL have port err  out  1  sticky frame error; clears on the next header byte.

Function
REQ-017 Frame format SHALL be: byte0 header (MSB = write, bits[ADDR_W-1:0] = start address), byte1 count N, then N data bytes for writes only.
REQ-018 States SHALL be IDLE, COUNT, WR_DATA, WR_ISSUE, RD_ISSUE, ERROR.
REQ-019 IDLE + SPI_done SHALL latch header, clear err, and go to COUNT.
REQ-020 COUNT + SPI_done with N=0 or N>MAX_LEN SHALL set err and go to ERROR; otherwise SHALL latch N and go to WR_DATA (write) or RD_ISSUE (read).
REQ-021 WR_DATA + SPI_done SHALL latch the byte into cmd_wdata and go to WR_ISSUE; cmd_valid SHALL be high the next cycle, one cycle of latency.
REQ-022 cmd_valid, cmd_write, cmd_addr and cmd_wdata SHALL be held stable until the cycle with cmd_valid && cmd_ready.
REQ-023 On acceptance, address SHALL increment modulo 2^ADDR_W (wrap allowed) and remaining count SHALL decrement; at zero go to IDLE, else WR_DATA or stay in RD_ISSUE.
REQ-024 RD_ISSUE SHALL issue reads back-to-back; cmd_valid SHALL stay high across consecutive accepted reads with no gap cycle.
REQ-025 SPI_done in WR_ISSUE (overrun) SHALL drop the byte, set err, deassert cmd_valid, and go to ERROR.
REQ-026 SPI_done in RD_ISSUE SHALL be ignored.
REQ-027 ERROR SHALL ignore SPI_done and leave only on SPI_cs_n high.
REQ-028 SPI_cs_n high in any state SHALL force IDLE next cycle and deassert cmd_valid, even when cmd_ready is high in the same cycle; that access is treated as not accepted.
REQ-029 SPI_cs_n high during COUNT, WR_DATA or WR_ISSUE SHALL set err; in IDLE or RD_ISSUE it SHALL NOT set err.

Reset
REQ-030 reset SHALL give state IDLE and cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, SPI_CMD_reading=0, err=0, count=0, timer=0.
REQ-031 reset SHALL take priority over every other input, including mid-burst.

Configuration
REQ-032 With SPI_CMD_TIMEOUT_EN defined, a timer SHALL clear on each SPI_done and whenever the state is not COUNT or WR_DATA.
REQ-033 With SPI_CMD_TIMEOUT_EN defined, the timer reaching TIMEOUT_CYC in COUNT or WR_DATA SHALL set err and go to IDLE.
REQ-034 Without SPI_CMD_TIMEOUT_EN, no timer logic SHALL exist, and COUNT and WR_DATA SHALL wait indefinitely.

Structure
REQ-035 Package spi_cmd_pkg SHALL hold the state enum, the header bit-field positions, and the default parameter constants.
REQ-036 Sub-module spi_cmd_timeout SHALL hold the inter-byte timer and be instantiated only under SPI_CMD_TIMEOUT_EN.

Verification
REQ-037 Write burst: bytes 0x85, 0x02, 0xAA, 0xBB, cmd_ready=1 -> writes (addr 0x05, data 0xAA) then (addr 0x06, data 0xBB); state returns to IDLE; err=0.
REQ-038 Read burst with stalls: bytes 0x7E, 0x03, cmd_ready low 2 cycles then high -> reads at addr 0x7E, 0x7F, 0x00 (wrap); SPI_CMD_reading high throughout; outputs stable while stalled.
REQ-039 Count error: header 0x80 then count 0x00 -> err=1, state ERROR, no cmd_valid; SPI_cs_n pulse -> IDLE; next header clears err.
REQ-040 Overrun: write frame, cmd_ready=0, second data byte arrives -> err=1, cmd_valid drops, state ERROR.
REQ-041 Abort: SPI_cs_n high mid-WR_ISSUE with cmd_ready=1 the same cycle -> no acceptance counted, state IDLE, err=1; reset mid-burst -> all outputs at reset values next cycle.
REQ-042 Timeout: with SPI_CMD_TIMEOUT_EN, TIMEOUT_CYC=8, header then silence -> err=1 and IDLE after 8 cycles; without the macro -> remains in COUNT.
